// File: rtl/me_search_sched.sv
`default_nettype none
// ============================================================================
// Module   : me_search_sched
// Purpose  : Search-window scheduler for the motion-estimation PE array.
//            Preloads the current block, then walks the search window column
//            by column. A column runs as two down-sampled passes (pair 12,
//            then pair 34) or as four full-sampled passes (one per
//            sub-block). Each presented step drives the PE array controls.
// Ports    : clk, rst_n (async, active low)
//            start  - begin a window (sampled in IDLE only)
//            stall  - freeze the schedule for this cycle
//            abort  - return to IDLE, highest priority after reset
//            in_curr_enable, CB_select, abs_control, change_ref,
//            ref_input_control - PE array controls (registered)
//            search_column_count, search_row_count - step being presented
//            busy, col_done, done - status / handshake
// Config   : ME_SCHED_FULL_REGION_EN - when defined, columns in
//            [FULL_LO, FULL_HI) run full-sampled; otherwise every column
//            is down-sampled and the FULL state is not built.
// Revision : 1.0 - initial release
// ============================================================================
module me_search_sched #(
  parameter int N_COLS       = 32,
  parameter int COL_W        = 6,
  parameter int ROW_W        = 7,
  parameter int PRE_CYCLES   = 32,
  parameter int ROWS_DS      = 38,
  parameter int PRELOAD_DS   = 8,
  parameter int ROWS_FULL    = 21,
  parameter int PRELOAD_FULL = 4,
  parameter int FULL_LO      = 8,
  parameter int FULL_HI      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  output logic             in_curr_enable,
  output logic             CB_select,
  output logic [1:0]       abs_control,
  output logic             change_ref,
  output logic             ref_input_control,
  output logic [COL_W-1:0] search_column_count,
  output logic [ROW_W-1:0] search_row_count,
  output logic             busy,
  output logic             col_done,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DS   = 3'd2,
`ifdef ME_SCHED_FULL_REGION_EN
    S_FULL = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  localparam logic [ROW_W-1:0] c_pre_last   = ROW_W'(PRE_CYCLES - 1);
  localparam logic [ROW_W-1:0] c_pre_cycles = ROW_W'(PRE_CYCLES);
  localparam logic [ROW_W-1:0] c_ds_last    = ROW_W'(ROWS_DS - 1);
  localparam logic [ROW_W-1:0] c_ds_tail    = ROW_W'(ROWS_DS - 4);
  localparam logic [ROW_W-1:0] c_preload_ds = ROW_W'(PRELOAD_DS);
  localparam logic [COL_W-1:0] c_col_last   = COL_W'(N_COLS - 1);
`ifdef ME_SCHED_FULL_REGION_EN
  localparam logic [ROW_W-1:0] c_full_last    = ROW_W'(ROWS_FULL - 1);
  localparam logic [ROW_W-1:0] c_preload_full = ROW_W'(PRELOAD_FULL);
  localparam logic [COL_W-1:0] c_full_lo      = COL_W'(FULL_LO);
  localparam logic [COL_W-1:0] c_full_hi      = COL_W'(FULL_HI);
`endif

  // Elaboration-time sanity checks on the parameter set.
  if ((2 ** COL_W) <= N_COLS) begin : g_chk_col_w
    $error("me_search_sched: COL_W too narrow for N_COLS");
  end
  if ((ROWS_DS < PRE_CYCLES) || (ROWS_DS < PRELOAD_DS + 4)) begin : g_chk_rows_ds
    $error("me_search_sched: ROWS_DS too small");
  end
  if ((ROWS_FULL <= PRELOAD_FULL) || (FULL_LO > FULL_HI) || (FULL_HI > N_COLS)) begin : g_chk_full
    $error("me_search_sched: inconsistent full-sampled region parameters");
  end

  // Step currently presented on the outputs.
  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       pass_q, pass_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic             ice_q, ice_d;
  logic             cb_q, cb_d;
  logic [1:0]       abs_q, abs_d;
  logic             cr_q, cr_d;
  logic             ric_q, ric_d;
  logic             busy_q, busy_d;
  logic             col_done_q, col_done_d;
  logic             done_q, done_d;

  logic [COL_W-1:0] col_inc;
  logic             last_row;
  logic             last_pass;
  logic             active;
  state_t           first_col_mode;
  state_t           next_col_mode;

  assign col_inc = col_q + 1'b1;

`ifdef ME_SCHED_FULL_REGION_EN
  function automatic state_t col_mode(input logic [COL_W-1:0] c);
    return ((c >= c_full_lo) && (c < c_full_hi)) ? S_FULL : S_DS;
  endfunction

  assign first_col_mode = col_mode('0);
  assign next_col_mode  = col_mode(col_inc);
  assign active = (state_q == S_PRE) || (state_q == S_DS) || (state_q == S_FULL);
`else
  assign first_col_mode = S_DS;
  assign next_col_mode  = S_DS;
  assign active = (state_q == S_PRE) || (state_q == S_DS);
`endif

  // Next step of the schedule (used only when not stalled / aborted).
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pass_d    = pass_q;
    row_d     = row_q;
    last_row  = (row_q == c_ds_last);
    last_pass = (pass_q == 2'd1);
`ifdef ME_SCHED_FULL_REGION_EN
    if (state_q == S_FULL) begin
      last_row  = (row_q == c_full_last);
      last_pass = (pass_q == 2'd3);
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRE;
          col_d   = '0;
          pass_d  = '0;
          row_d   = '0;
        end
      end
      S_PRE: begin
        if (row_q == c_pre_last) begin
          state_d = first_col_mode;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
`ifdef ME_SCHED_FULL_REGION_EN
      S_DS, S_FULL: begin
`else
      S_DS: begin
`endif
        if (last_row) begin
          row_d = '0;
          if (last_pass) begin
            pass_d = '0;
            if (col_q == c_col_last) begin
              state_d = S_DONE;
              col_d   = '0;
            end else begin
              state_d = next_col_mode;
              col_d   = col_inc;
            end
          end else begin
            pass_d = pass_q + 2'd1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        col_d   = '0;
        pass_d  = '0;
        row_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controls for the step about to be presented, decoded from the next step
  // so that they land in registers alongside the counters.
  always_comb begin
    ice_d      = 1'b0;
    cb_d       = 1'b1;
    abs_d      = 2'd0;
    cr_d       = 1'b0;
    ric_d      = 1'b0;
    busy_d     = 1'b0;
    col_done_d = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_PRE: begin
        ice_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_DS: begin
        busy_d = 1'b1;
        ric_d  = 1'b1;
        cb_d   = ~pass_d[0];
        // abs_control base is 2*pass, so the pass bit is the MSB.
        if (row_d < c_preload_ds) begin
          abs_d = {pass_d[0], 1'b0};
          cr_d  = 1'b1;
        end else if (row_d < c_ds_tail) begin
          abs_d = {pass_d[0], ~row_d[0]};
          cr_d  = row_d[0];
        end else begin
          abs_d = {pass_d[0], 1'b1};
          cr_d  = 1'b1;
        end
        // Pair 34 is loaded in the background during column 0, pass 0.
        if ((col_d == '0) && (pass_d == 2'd0) && (row_d < c_pre_cycles)) begin
          ice_d = 1'b1;
          cb_d  = 1'b0;
        end
        col_done_d = (pass_d == 2'd1) && (row_d == c_ds_last);
      end
`ifdef ME_SCHED_FULL_REGION_EN
      S_FULL: begin
        busy_d     = 1'b1;
        abs_d      = pass_d;
        cb_d       = 1'b0;
        cr_d       = 1'b1;
        ric_d      = (row_d < c_preload_full);
        col_done_d = (pass_d == 2'd3) && (row_d == c_full_last);
      end
`endif
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      pass_q     <= '0;
      row_q      <= '0;
      ice_q      <= 1'b0;
      cb_q       <= 1'b1;
      abs_q      <= 2'd0;
      cr_q       <= 1'b0;
      ric_q      <= 1'b0;
      busy_q     <= 1'b0;
      col_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      pass_q     <= '0;
      row_q      <= '0;
      ice_q      <= 1'b0;
      cb_q       <= 1'b1;
      abs_q      <= 2'd0;
      cr_q       <= 1'b0;
      ric_q      <= 1'b0;
      busy_q     <= 1'b0;
      col_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (stall && active) begin
      // Hold the step; suppress the side-effecting strobes so the PE array
      // does not load or shift twice for the same step.
      ice_q      <= 1'b0;
      cr_q       <= 1'b0;
      col_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      pass_q     <= pass_d;
      row_q      <= row_d;
      ice_q      <= ice_d;
      cb_q       <= cb_d;
      abs_q      <= abs_d;
      cr_q       <= cr_d;
      ric_q      <= ric_d;
      busy_q     <= busy_d;
      col_done_q <= col_done_d;
      done_q     <= done_d;
    end
  end

  assign in_curr_enable      = ice_q;
  assign CB_select           = cb_q;
  assign abs_control         = abs_q;
  assign change_ref          = cr_q;
  assign ref_input_control   = ric_q;
  assign search_column_count = col_q;
  assign search_row_count    = row_q;
  assign busy                = busy_q;
  assign col_done            = col_done_q;
  assign done                = done_q;

endmodule
`default_nettype wire

// File: doc/me_search_sched.md
# me_search_sched

Parametrised search-window scheduler for the motion-estimation PE array. It sequences the current-block preload, then walks the search window column by column. Each column runs either as down-sampled passes (two passes: sub-block pair 12, then pair 34) or as full-sampled passes (four passes, one per sub-block). Each cycle it drives the PE array's current-block load, sub-block select, abs-difference routing, reference shift and reference-input-source controls. It adds start/busy/done handshaking, a stall input and an abort input.

## Interface
- N_COLS, 32: search columns per window.
- COL_W, 6: width of the column counter; must satisfy 2^COL_W > N_COLS.
- ROW_W, 7: width of the row counter.
- PRE_CYCLES, 32: current-block preload cycles for pair 12.
- ROWS_DS, 38: rows per down-sampled pass; must be >= PRE_CYCLES and >= PRELOAD_DS+4.
- PRELOAD_DS, 8: leading shift-only rows in a down-sampled pass.
- ROWS_FULL, 21: rows per full-sampled pass.
- PRELOAD_FULL, 4: leading external-reference rows in a full pass.
- FULL_LO, 8: first full-sampled column (inclusive).
- FULL_HI, 24: last full-sampled column (exclusive).
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a window; sampled only in IDLE.
- stall, input, 1: freeze the schedule for this cycle.
- abort, input, 1: return to IDLE; takes priority over everything except reset.
- in_curr_enable, output, 1: current-block memory write enable.
- CB_select, output, 1: 1 = sub-block pair 12, 0 = pair 34 / full mode.
- abs_control, output, 2: abs-difference routing selector.
- change_ref, output, 1: shift the reference register chain.
- ref_input_control, output, 1: 1 = external reference input, 0 = internal recirculation.
- search_column_count, output, COL_W: current column.
- search_row_count, output, ROW_W: current row within the pass.
- busy, output, 1: high in PRE, DS and FULL.
- col_done, output, 1: one-cycle pulse on the last row of a column.
- done, output, 1: one-cycle pulse after the last column completes.

## Operation
- States are IDLE, PRE, DS, FULL and DONE. Internal counters are col, pass (2 bits) and row.
- Column mode: the column is FULL when FULL_LO <= col < FULL_HI, otherwise DS.
- IDLE: start -> PRE, with all counters cleared.
- PRE: runs PRE_CYCLES steps.
  - in_curr_enable=1, CB_select=1, change_ref=0.
  - After the last step, go to DS or FULL according to the mode of column 0.
- DS pass p (0 = pair 12, 1 = pair 34), with base = 2p and ref_input_control=1:
  - row < PRELOAD_DS: abs_control=base, change_ref=1.
  - row < ROWS_DS-4: even row -> abs_control=base+1, change_ref=0. Odd row -> abs_control=base, change_ref=1.
  - Remaining rows: abs_control=base+1, change_ref=1.
  - CB_select=1 in pass 0, 0 in pass 1.
  - Column 0, pass 0, row < PRE_CYCLES: in_curr_enable=1 and CB_select=0 (background load of pair 34). Otherwise in_curr_enable=0.
- FULL pass p (0..3):
  - abs_control=p, CB_select=0, change_ref=1, in_curr_enable=0.
  - ref_input_control=1 when row < PRELOAD_FULL, else 0.
- Row wrap: at the last row of a pass, row resets to 0 and pass increments.
- Column wrap: on the last pass (1 in DS, 3 in FULL), pass resets to 0, col increments and col_done pulses. The next state is chosen from the mode of the new column.
- When col wraps from N_COLS-1: DONE for one cycle (done=1), then IDLE.
- search_column_count and search_row_count always equal col and row of the step being presented.

## Timing
- All outputs are registered.
  - The step-0 PRE controls appear in the cycle after start is sampled high.
  - Each later step appears one cycle after the previous step, except when stalled.
- Reset values: every output is 0, except CB_select=1. State is IDLE and all counters are 0.
- stall=1 in PRE, DS or FULL:
  - Counters and state hold.
  - in_curr_enable=0, change_ref=0 and col_done=0 for that cycle.
  - Other outputs hold.
  - When stall is released, the same step is re-presented.
- stall in IDLE or DONE is ignored.
- abort=1 in any state: next cycle is IDLE with outputs at their reset values. No done pulse is produced.
- start while busy is ignored. start in the DONE cycle is ignored. start sampled in IDLE the following cycle is accepted.
- Window length without stalls, defaults, FULL region compiled in: 32 + 16·2·38 + 16·4·21 = 2592 busy cycles, then 1 DONE cycle.

## Configuration
- ME_SCHED_FULL_REGION_EN defined: the column mode follows FULL_LO/FULL_HI as described above.
- ME_SCHED_FULL_REGION_EN undefined:
  - Every column is DS and the FULL state logic is not compiled.
  - Default window is 32 + 32·76 = 2464 busy cycles.

## Test plan
- Reset mid-window: assert rst_n=0 during column 5 of DS. All outputs return to reset values immediately; CB_select=1; busy=0.
- Nominal window with defaults: pulse start. busy stays high for exactly 2592 cycles, col_done pulses 32 times, then done pulses once.
- Column 0 DS schedule:
  - in_curr_enable=1 for 32 PRE cycles with CB_select=1.
  - Then 32 more cycles with CB_select=0.
  - Row 8 gives abs_control=1, change_ref=0; row 9 gives abs_control=0, change_ref=1.
  - Pass 1, row 34 gives abs_control=3, change_ref=1.
- FULL column 8: abs_control steps 0,1,2,3, each held for 21 rows. ref_input_control=1 on rows 0–3 only.
- Stall: hold stall=1 for 5 cycles at DS row 12. search_row_count stays at 12, change_ref=0, and total window length grows by 5.
- Abort and restart: abort at column 20. Next cycle is IDLE with no done pulse. A new start replays the full schedule from column 0.
